trace_request_scheduler: RTL

- Consumes parsed trace records (time, op, address) and releases each one downstream only when simulation time reaches the record's timestamp.
- The parser produces records; this block is the receiving end. It buffers the records in a FIFO and presents them to the memory-controller request queue over a valid/ready handshake.
- It owns the free-running CPU-cycle counter that defines "simulation time".

---
 rtl/trace_request_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/trace_request_scheduler.sv
// trace_request_scheduler
//   Buffers parsed trace records (time, op, address) in a FIFO and releases the
//   head record downstream once the free-running CPU-cycle counter reaches the
//   record's timestamp. Also owns that counter (cur_time), which saturates.
//
// Parameters
//   DEPTH  : FIFO entries (power of two, >= 2)
//   TIME_W : timestamp / cycle-counter width
//   ADDR_W : address width
//
// Ports
//   clk, rst           : clock; asynchronous active-high reset
//   in_valid/in_ready  : record handshake from the parser
//   in_time/op/addr    : record fields (op 0=read 1=write 2=ifetch 3=illegal)
//   out_valid/ready    : released-head handshake to the request queue
//   out_time/op/addr   : head record fields (zero when empty)
//   cur_time           : current CPU cycle
//   count/full/empty   : FIFO occupancy status
//   order_err          : sticky, a timestamp went backwards between accepted records
//   op_err             : sticky, an op=3 record was offered and dropped
module trace_request_scheduler #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TIME_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TIME_W-1:0]        in_time,
  input  logic [1:0]               in_op,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TIME_W-1:0]        out_time,
  output logic [1:0]               out_op,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [TIME_W-1:0]        cur_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     order_err,
  output logic                     op_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OpIllegal = 2'd3;

  // Record storage; no reset needed since head fields are masked while empty.
  logic [TIME_W-1:0] mem_time [DEPTH];
  logic [1:0]        mem_op   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TIME_W-1:0] cur_time_q, cur_time_d;
  logic [TIME_W-1:0] last_time_q, last_time_d;
  logic              seen_push_q, seen_push_d;
  logic              order_err_q, order_err_d;
  logic              op_err_q, op_err_d;

  logic accept;
  logic push;
  logic pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    in_ready = !full;

    if (empty) begin
      out_time = '0;
      out_op   = '0;
      out_addr = '0;
    end else begin
      out_time = mem_time[rd_ptr_q];
      out_op   = mem_op[rd_ptr_q];
      out_addr = mem_addr[rd_ptr_q];
    end

    out_valid = !empty && (out_time <= cur_time_q);

    accept = in_valid && in_ready;
    push   = accept && (in_op != OpIllegal);
    pop    = out_valid && out_ready;

    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    cur_time_d  = (cur_time_q == '1) ? cur_time_q : cur_time_q + TIME_W'(1);

    last_time_d = push ? in_time : last_time_q;
    seen_push_d = seen_push_q || push;

    // seen_push_q keeps the very first record after reset from being
    // compared against the reset value of last_time_q.
    order_err_d = order_err_q || (push && seen_push_q && (in_time < last_time_q));
    op_err_d    = op_err_q || (accept && (in_op == OpIllegal));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cur_time_q  <= '0;
      last_time_q <= '0;
      seen_push_q <= 1'b0;
      order_err_q <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      cur_time_q  <= cur_time_d;
      last_time_q <= last_time_d;
      seen_push_q <= seen_push_d;
      order_err_q <= order_err_d;
      op_err_q    <= op_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr_q] <= in_time;
      mem_op[wr_ptr_q]   <= in_op;
      mem_addr[wr_ptr_q] <= in_addr;
    end
  end

  assign cur_time  = cur_time_q;
  assign count     = count_q;
  assign order_err = order_err_q;
  assign op_err    = op_err_q;

endmodule
